// File: rtl/zmenu_pkg.sv
// Shared types for the TFT43 menu sequencer: controller states and the
// button-priority resolution used when several pulses land in one cycle.
package zmenu_pkg;

  typedef enum logic [1:0] {
    BROWSE,
    EDIT,
    COMMIT
  } state_t;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_CANCEL,
    BTN_OKAY,
    BTN_PREV,
    BTN_NEXT
  } btn_t;

  // Cancel > Okay > Prev > Next; only the winner acts.
  function automatic btn_t btn_resolve(input logic prev, input logic next,
                                       input logic okay, input logic cancel);
    if (cancel)    return BTN_CANCEL;
    else if (okay) return BTN_OKAY;
    else if (prev) return BTN_PREV;
    else if (next) return BTN_NEXT;
    else           return BTN_NONE;
  endfunction

endpackage

// File: rtl/zmenu_param_bank.sv
// Shadow parameter bank: last committed value per menu item, one write port,
// a registered display read port and a combinational port for seeding edits.
module zmenu_param_bank #(
  parameter  int unsigned NUM_ITEMS = 11,
  parameter  int unsigned VAL_W     = 8,
  localparam int unsigned IW        = $clog2(NUM_ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [VAL_W-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [VAL_W-1:0] rdata,
  input  logic [IW-1:0]    seed_addr,
  output logic [VAL_W-1:0] seed_data
);

  localparam logic [IW-1:0] NUM = IW'(NUM_ITEMS);

  logic [VAL_W-1:0] mem [NUM_ITEMS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && waddr < NUM) mem[waddr] <= wdata;
      // Same-cycle read of the written entry returns the old value.
      rdata <= (raddr < NUM) ? mem[raddr] : '0;
    end
  end

  assign seed_data = (seed_addr < NUM) ? mem[seed_addr] : '0;

endmodule

// File: rtl/zmenu_controller.sv
// Menu navigation / parameter edit sequencer with valid/ready commit output.
// Define ZMENU_TIMEOUT_EN to abandon an edit after TIMEOUT_CYC idle cycles.
module zmenu_controller
  import zmenu_pkg::*;
#(
  parameter  int unsigned NUM_ITEMS   = 11,
  parameter  int unsigned VAL_W       = 8,
  parameter  int unsigned TIMEOUT_CYC = 50_000_000,
  localparam int unsigned IW          = $clog2(NUM_ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iPrev,
  input  logic             iNext,
  input  logic             iOkay,
  input  logic             iCancel,
  output logic [IW-1:0]    oCursor,
  output logic             oEditing,
  output logic [VAL_W-1:0] oEditValue,
  output logic             oCommitValid,
  output logic [IW-1:0]    oCommitAddr,
  output logic [VAL_W-1:0] oCommitData,
  input  logic             iCommitReady,
  input  logic [IW-1:0]    iRdAddr,
  output logic [VAL_W-1:0] oRdData
);

  localparam logic [IW-1:0] LAST = IW'(NUM_ITEMS - 1);

  state_t           state;
  btn_t             win;
  logic             edit_timeout;
  logic [VAL_W-1:0] seed_data;

  always_comb begin
    win = BTN_NONE;
    if (en) win = btn_resolve(iPrev, iNext, iOkay, iCancel);
  end

`ifdef ZMENU_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Runs only while editing; any accepted pulse restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  idle_cnt <= '0;
    else if (state != EDIT || win != BTN_NONE) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + 32'd1;
  end

  assign edit_timeout = (state == EDIT) && (win == BTN_NONE) &&
                        (idle_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign edit_timeout       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BROWSE;
      oCursor      <= '0;
      oEditing     <= 1'b0;
      oEditValue   <= '0;
      oCommitValid <= 1'b0;
      oCommitAddr  <= '0;
      oCommitData  <= '0;
    end else begin
      unique case (state)
        BROWSE: begin
          if (!en) oCursor <= '0;
          else begin
            case (win)
              BTN_PREV: oCursor <= (oCursor == '0) ? LAST : oCursor - 1'b1;
              BTN_NEXT: oCursor <= (oCursor == LAST) ? '0 : oCursor + 1'b1;
              BTN_OKAY: begin
                oEditValue <= seed_data;
                oEditing   <= 1'b1;
                state      <= EDIT;
              end
              default: ;
            endcase
          end
        end
        EDIT: begin
          if (!en || win == BTN_CANCEL || edit_timeout) begin
            oEditing <= 1'b0;
            state    <= BROWSE;
            if (!en) oCursor <= '0;
          end else begin
            case (win)
              BTN_PREV: if (oEditValue != '0) oEditValue <= oEditValue - 1'b1;
              BTN_NEXT: if (oEditValue != '1) oEditValue <= oEditValue + 1'b1;
              BTN_OKAY: begin
                oCommitAddr  <= oCursor;
                oCommitData  <= oEditValue;
                oCommitValid <= 1'b1;
                oEditing     <= 1'b0;
                state        <= COMMIT;
              end
              default: ;
            endcase
          end
        end
        // en is deliberately ignored here: the handshake must finish first,
        // and BROWSE then applies en low on the following cycle.
        COMMIT: begin
          if (iCommitReady) begin
            oCommitValid <= 1'b0;
            state        <= BROWSE;
          end
        end
        default: state <= BROWSE;
      endcase
    end
  end

  zmenu_param_bank #(
    .NUM_ITEMS(NUM_ITEMS),
    .VAL_W    (VAL_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (oCommitValid && iCommitReady),
    .waddr    (oCommitAddr),
    .wdata    (oCommitData),
    .raddr    (iRdAddr),
    .rdata    (oRdData),
    .seed_addr(oCursor),
    .seed_data(seed_data)
  );

endmodule

// File: doc/zmenu_controller.md
# zmenu_controller

Menu-navigation and parameter-edit sequencer for the TFT43 front panel. It consumes debounced single-cycle button pulses (Previous/Next/Okay/Cancel) and moves a cursor over a fixed list of menu items. It lets the operator edit the selected item's value and hands each committed value to the downstream configuration logic over a valid/ready handshake. A shadow parameter bank inside the block holds the last committed value of every item, for display and for seeding edits.

## Interface
Parameters:
- NUM_ITEMS, 11, number of menu items; cursor range 0..NUM_ITEMS-1
- VAL_W, 8, parameter value width
- TIMEOUT_CYC, 50_000_000, edit inactivity limit in clk cycles (used only with ZMENU_TIMEOUT_EN)

Ports (IW = $clog2(NUM_ITEMS)):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; low forces browse state with cursor 0 (see Operation)
- iPrev / iNext / iOkay / iCancel  in  1 each  debounced single-cycle button pulses
- oCursor  out  IW  current menu item index
- oEditing  out  1  high while in EDIT
- oEditValue  out  VAL_W  working value being edited
- oCommitValid  out  1  commit request
- oCommitAddr  out  IW  item index of the commit; stable while valid
- oCommitData  out  VAL_W  committed value; stable while valid
- iCommitReady  in  1  downstream accepts the commit when high with valid
- iRdAddr  in  IW  shadow bank read address (display)
- oRdData  out  VAL_W  shadow bank read data, registered

## Operation
- States: BROWSE (reset), EDIT, COMMIT.
- Same-cycle pulses resolve by priority Cancel > Okay > Prev > Next. Only the winner acts.
- BROWSE:
  - Prev: cursor decrements, 0 wraps to NUM_ITEMS-1.
  - Next: cursor increments, NUM_ITEMS-1 wraps to 0.
  - Okay: oEditValue <= bank[oCursor], go to EDIT.
  - Cancel: no effect.
- EDIT:
  - Prev decrements oEditValue, saturating at 0.
  - Next increments oEditValue, saturating at 2^VAL_W-1.
  - Okay: latch addr=oCursor and data=oEditValue, assert oCommitValid, go to COMMIT.
  - Cancel: discard the edit, go to BROWSE. Bank is unchanged.
  - Cursor is frozen.
- COMMIT:
  - All buttons are ignored.
  - On oCommitValid && iCommitReady: write bank[oCommitAddr] <= oCommitData, deassert valid, go to BROWSE.
  - Valid never drops without acceptance.
- en low:
  - In BROWSE or EDIT: next state is BROWSE, cursor 0, edit discarded.
  - In COMMIT: the handshake completes first, then en low applies.
  - Buttons are ignored while en is low.
- Reset values: state BROWSE; oCursor 0; oEditing 0; oEditValue 0; oCommitValid 0; oCommitAddr 0; oCommitData 0; oRdData 0; all bank entries 0.
- Reset mid-COMMIT drops valid immediately and writes nothing to the bank.

## Timing
- All outputs are registered.
- Button pulse in cycle N → cursor, value or state update visible in cycle N+1.
- Okay in EDIT at cycle N → oCommitValid high at N+1.
- Acceptance at cycle M → bank updated and state BROWSE at M+1. The earliest new Okay that acts is at M+1.
- oRdData = bank[iRdAddr] one cycle after the address is presented.
- A read of the address being written in the same cycle returns the old value.
- iCommitReady may be held high permanently; commit then takes exactly one cycle in COMMIT.

## Configuration
- ZMENU_TIMEOUT_EN defined:
  - An inactivity counter clears on EDIT entry and on every accepted button pulse.
  - If it reaches TIMEOUT_CYC-1 while in EDIT, the next cycle goes to BROWSE and the edit is discarded, exactly as Cancel.
  - The counter does not run in BROWSE or COMMIT.
- ZMENU_TIMEOUT_EN undefined: no counter; EDIT persists indefinitely.

## Structure
- Package zmenu_pkg: state enum (BROWSE, EDIT, COMMIT) and the button priority encoding constants.
- Sub-module zmenu_param_bank: NUM_ITEMS x VAL_W register array with asynchronous reset, one write port and a registered read port.

## Test plan
- Cursor wrap: reset, 1x iPrev → oCursor=10; 1x iNext → oCursor=0; 11x iNext → oCursor=0.
- Full commit: cursor=3, Okay, 5x Next, Okay, iCommitReady held low 4 cycles → oCommitValid stays high with addr=3, data=5. Raise ready → bank[3]=5, and iRdAddr=3 gives oRdData=5 one cycle later.
- Edit saturation and cancel:
  - Edit bank value 0: Prev keeps 0.
  - Seed 255 via commit, then Next keeps 255.
  - Cancel → BROWSE with bank unchanged.
- Priority: iOkay and iCancel together in EDIT → BROWSE, no commit. iPrev and iNext together in BROWSE from cursor 4 → cursor 3.
- en and reset:
  - en low in EDIT → BROWSE, cursor 0.
  - en low in COMMIT → valid held until ready, then BROWSE.
  - rst pulse in COMMIT → valid 0 and bank entry unwritten.
- Timeout (macro on, TIMEOUT_CYC=16): Okay to enter EDIT, no buttons for 16 cycles → BROWSE, no commit. Same test with the macro off → remains in EDIT.
